digit_scan_sched: RTL
=====================

DIGIT_SCAN_SCHED -- requirements
Module: digit_scan_sched

Interface
REQ-001 The block SHALL have parameter SLOT_CYC, default 1000, meaning clock cycles per scan slot (legal range 4..65535).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, meaning blanked cycles at the start of each digit slot (legal range 1..SLOT_CYC-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port A, B, C, inputs, 4 bits each: the new digit values; A is most significant.
REQ-006 The block SHALL have port upd_req, input, 1 bit: a level request to load A/B/C into the shadow registers.
REQ-007 The block SHALL have port upd_ack, output, 1 bit: a one-cycle acknowledge that the capture occurred.
REQ-008 The block SHALL have ports com_1, com_2, com_3, outputs, 1 bit each: active-low digit commons for A, B and C.
REQ-009 The block SHALL have port sel, output, 2 bits: the current slot index (0 = LOAD, 1/2/3 = digit A/B/C).
REQ-010 The block SHALL have port dig_data, output, 4 bits: the value of the driven digit, for an external BCD-to-7-segment decoder.
REQ-011 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse on the first cycle of each frame.

Function
REQ-012 The block SHALL hold internal state: slot (2 bits), cnt (0..SLOT_CYC-1), and 4-bit shadow registers shA, shB, shC.
REQ-013 cnt SHALL increment every cycle; when it reaches SLOT_CYC-1 it wraps to 0 and slot advances 0->1->2->3->0. Frame length SHALL be 4*SLOT_CYC cycles.
REQ-014 sel SHALL equal slot.
REQ-015 Slot 0 is the LOAD slot: com_1..com_3 SHALL all be 1 and dig_data SHALL be 4'hF (decodes to all segments off).
REQ-016 In slot n (n = 1..3), com_n SHALL be 0 only when cnt >= BLANK_CYC; all other commons SHALL be 1; at most one common SHALL be low in any cycle.
REQ-017 In slot n, dig_data SHALL be the matching shadow value while com_n is low, and 4'hF otherwise.
REQ-018 frame_start SHALL be 1 exactly when slot==0 and cnt==0.
REQ-019 On a clock edge with slot==0, cnt==0 and upd_req==1, shA/shB/shC SHALL capture A/B/C.
REQ-020 upd_ack SHALL be 1 for exactly the one cycle following a capture; a request arriving at any other time SHALL wait for the next frame start (worst-case latency 4*SLOT_CYC+1 cycles).
REQ-021 Requesters SHALL hold A/B/C stable while upd_req is 1 and SHALL drop upd_req in the ack cycle; if upd_req is still 1 at the next frame start, a new capture and ack SHALL occur.
REQ-022 Shadow values SHALL change only at a capture, so the displayed data never tears mid-frame.
REQ-023 Outputs SHALL be decoded from registered state only, with no combinational path from A/B/C/upd_req to any output.

Reset
REQ-024 While rst=1: slot=0, cnt=0, shA/shB/shC=0, upd_ack=0, frame_start=0, com_1..com_3=1, sel=0, dig_data=4'hF.
REQ-025 Reset mid-frame or mid-handshake SHALL abort the frame; a pending request SHALL be acked only at a later capture. The first cycle after rst falls SHALL be a frame start.

Configuration
REQ-026 When macro DIGIT_SCAN_LZB_EN is defined, leading-zero blanking SHALL apply: com_1 stays 1 in slot 1 if shA==0; com_2 stays 1 in slot 2 if shA==0 and shB==0; digit C is never blanked; dig_data is 4'hF while its digit is blanked.
REQ-027 When DIGIT_SCAN_LZB_EN is undefined, every digit SHALL be driven per REQ-016 regardless of value, and no LZB logic SHALL be synthesized.

Verification (SLOT_CYC=8, BLANK_CYC=2; cycle 0 = first cycle after rst falls)
REQ-028 The bench SHALL cover free-run after reset: frame_start=1 at cycles 0 and 32; com_1 low in cycles 10-15, com_2 in 18-23, com_3 in 26-31; dig_data=0 while driven; commons never overlap.
REQ-029 The bench SHALL cover an update: upd_req=1 at cycle 3 with A=1, B=2, C=3 -> capture at cycle 32, upd_ack=1 only in cycle 33; dig_data=1/2/3 in cycles 42-47, 50-55 and 58-63.
REQ-030 The bench SHALL cover a held request: upd_req held 1 from cycle 0 to 40 -> upd_ack=1 in cycles 1 and 33 only.
REQ-031 The bench SHALL cover reset mid-frame: rst=1 for one cycle at cycle 20 after a capture of 7/8/9 -> all commons 1, shadows 0, next frame_start on the cycle after rst falls.
REQ-032 With DIGIT_SCAN_LZB_EN, shadow values A=0/B=5/C=0 -> com_1 never low, com_2 shows 5, com_3 shows 0; with 0/0/0 only com_3 is driven.
REQ-033 Without DIGIT_SCAN_LZB_EN, the same 0/5/0 load -> all three commons driven, with values 0/5/0.

Source files
------------

// File: rtl/digit_scan_sched.sv
// Three-digit multiplexed display scanner: LOAD slot plus A/B/C digit slots, shadow registers captured only at frame start.
// Optional leading-zero blanking when DIGIT_SCAN_LZB_EN is defined.
module digit_scan_sched #(
  parameter int unsigned SLOT_CYC  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic       com_1,
  output logic       com_2,
  output logic       com_3,
  output logic [1:0] sel,
  output logic [3:0] dig_data,
  output logic       frame_start
);

  localparam int unsigned     CW        = $clog2(SLOT_CYC);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]   CNT_BLANK = CW'(BLANK_CYC);

  typedef enum logic [1:0] {
    SLOT_LOAD = 2'd0,
    SLOT_A    = 2'd1,
    SLOT_B    = 2'd2,
    SLOT_C    = 2'd3
  } slot_e;

  slot_e         slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sha_q, sha_d;
  logic [3:0]    shb_q, shb_d;
  logic [3:0]    shc_q, shc_d;
  logic          ack_q, ack_d;
  logic          capture;
  logic          lit;
  logic          lzb_a;
  logic          lzb_b;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    slot_d = slot_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = slot_e'(slot_q + 2'd1);
    end

    // Capture only on the very first cycle of a frame so a frame never mixes old and new digits.
    capture = (slot_q == SLOT_LOAD) && (cnt_q == '0) && upd_req;
    sha_d   = capture ? A : sha_q;
    shb_d   = capture ? B : shb_q;
    shc_d   = capture ? C : shc_q;
    ack_d   = capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_LOAD;
      cnt_q  <= '0;
      sha_q  <= 4'h0;
      shb_q  <= 4'h0;
      shc_q  <= 4'h0;
      ack_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      sha_q  <= sha_d;
      shb_q  <= shb_d;
      shc_q  <= shc_d;
      ack_q  <= ack_d;
    end
  end

`ifdef DIGIT_SCAN_LZB_EN
  assign lzb_a = (sha_q == 4'h0);
  assign lzb_b = lzb_a && (shb_q == 4'h0);
`else
  assign lzb_a = 1'b0;
  assign lzb_b = 1'b0;
`endif

  assign lit = (cnt_q >= CNT_BLANK);

  // Outputs depend only on registered state; rst forces the idle pattern in the same cycle.
  always_comb begin
    upd_ack     = 1'b0;
    com_1       = 1'b1;
    com_2       = 1'b1;
    com_3       = 1'b1;
    sel         = 2'd0;
    dig_data    = 4'hF;
    frame_start = 1'b0;
    if (!rst) begin
      upd_ack     = ack_q;
      sel         = slot_q;
      frame_start = (slot_q == SLOT_LOAD) && (cnt_q == '0);
      case (slot_q)
        SLOT_A: if (lit && !lzb_a) begin
          com_1    = 1'b0;
          dig_data = sha_q;
        end
        SLOT_B: if (lit && !lzb_b) begin
          com_2    = 1'b0;
          dig_data = shb_q;
        end
        SLOT_C: if (lit) begin
          com_3    = 1'b0;
          dig_data = shc_q;
        end
        default: ;
      endcase
    end
  end

endmodule
